// File: rtl/decode_ctrl_pkg.sv
// Shared definitions for the decode controller: RV32 opcode/funct constants,
// immediate-type and memory-mode enums, and the packed control bundle.
// Optional RV32M support is selected with the RV32M_EN macro in the decoder.
package decode_ctrl_pkg;

    localparam logic [6:0] OPC_LUI      = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPC_JAL      = 7'b1101111;
    localparam logic [6:0] OPC_JALR     = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPC_LOAD     = 7'b0000011;
    localparam logic [6:0] OPC_STORE    = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPC_OP       = 7'b0110011;
    localparam logic [6:0] OPC_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SR      = 3'b101;
    localparam logic [2:0] F3_JALR    = 3'b000;
    localparam logic [2:0] F3_FENCE   = 3'b000;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INST_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INST_EBREAK = 32'h0010_0073;

    typedef enum logic [2:0] {
        IMM_NOP = 3'd0,
        IMM_I   = 3'd1,
        IMM_S   = 3'd2,
        IMM_B   = 3'd3,
        IMM_U   = 3'd4,
        IMM_J   = 3'd5,
        IMM_R   = 3'd6
    } imm_type_e;

    // Encoded to match the load/store funct3 field directly.
    typedef enum logic [2:0] {
        MEM_BYTE  = 3'b000,
        MEM_HALF  = 3'b001,
        MEM_WORD  = 3'b010,
        MEM_BYTEU = 3'b100,
        MEM_HALFU = 3'b101
    } mem_mode_e;

    typedef struct packed {
        imm_type_e imm_type;
        logic      dmem_write;
        logic      dmem_read;
        mem_mode_e dmem_mode;
        logic      rf_write;
        logic      alu_src_imm;
        logic      wb_sel_mem;
        logic      branch;
        logic      jump;
        logic      jalr;
        logic      muldiv;
        logic      illegal;
    } ctrl_t;

    function automatic ctrl_t illegalCtrl();
        ctrl_t c;
        c          = '0;
        c.imm_type = IMM_NOP;
        c.illegal  = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/decode_ctrl_decoder.sv
// Combinational RV32I decoder producing the control bundle and operand-use
// flags. Define RV32M_EN to additionally accept the M-extension OP encodings.
module rv32_decoder
    import decode_ctrl_pkg::*;
(
    input  logic [31:0] i_inst,
    output ctrl_t       o_ctrl,
    output logic        o_rs1_used,
    output logic        o_rs2_used
);

    logic [6:0] w_opcode;
    logic [2:0] w_funct3;
    logic [6:0] w_funct7;

    assign w_opcode = i_inst[6:0];
    assign w_funct3 = i_inst[14:12];
    assign w_funct7 = i_inst[31:25];

    // Map the opcode/funct fields onto control signals; anything unmatched is illegal
    always_comb begin
        o_ctrl     = '0;
        o_rs1_used = 1'b0;
        o_rs2_used = 1'b0;
        case (w_opcode)
            OPC_LUI, OPC_AUIPC: begin
                o_ctrl.imm_type = IMM_U;
                o_ctrl.rf_write = 1'b1;
            end
            OPC_JAL: begin
                o_ctrl.imm_type = IMM_J;
                o_ctrl.rf_write = 1'b1;
                o_ctrl.jump     = 1'b1;
            end
            OPC_JALR: begin
                if (w_funct3 == F3_JALR) begin
                    o_ctrl.imm_type = IMM_I;
                    o_ctrl.rf_write = 1'b1;
                    o_ctrl.jalr     = 1'b1;
                    o_rs1_used      = 1'b1;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_BRANCH: begin
                if (w_funct3 != 3'b010 && w_funct3 != 3'b011) begin
                    o_ctrl.imm_type = IMM_B;
                    o_ctrl.branch   = 1'b1;
                    o_rs1_used      = 1'b1;
                    o_rs2_used      = 1'b1;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_LOAD: begin
                if (w_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}) begin
                    o_ctrl.imm_type   = IMM_I;
                    o_ctrl.dmem_read  = 1'b1;
                    o_ctrl.wb_sel_mem = 1'b1;
                    o_ctrl.rf_write   = 1'b1;
                    o_ctrl.dmem_mode  = mem_mode_e'(w_funct3);
                    o_rs1_used        = 1'b1;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_STORE: begin
                if (w_funct3 inside {3'b000, 3'b001, 3'b010}) begin
                    o_ctrl.imm_type   = IMM_S;
                    o_ctrl.dmem_write = 1'b1;
                    o_ctrl.dmem_mode  = mem_mode_e'(w_funct3);
                    o_rs1_used        = 1'b1;
                    o_rs2_used        = 1'b1;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_OP_IMM: begin
                if ((w_funct3 == F3_SLL && w_funct7 != F7_BASE) ||
                    (w_funct3 == F3_SR && w_funct7 != F7_BASE && w_funct7 != F7_ALT)) begin
                    o_ctrl = illegalCtrl();
                end else begin
                    o_ctrl.imm_type    = IMM_I;
                    o_ctrl.alu_src_imm = 1'b1;
                    o_ctrl.rf_write    = 1'b1;
                    o_rs1_used         = 1'b1;
                end
            end
            OPC_OP: begin
                if (w_funct7 == F7_BASE ||
                    (w_funct7 == F7_ALT && (w_funct3 == F3_ADD_SUB || w_funct3 == F3_SR))) begin
                    o_ctrl.imm_type = IMM_R;
                    o_ctrl.rf_write = 1'b1;
                    o_rs1_used      = 1'b1;
                    o_rs2_used      = 1'b1;
                end
`ifdef RV32M_EN
                else if (w_funct7 == F7_MULDIV) begin
                    o_ctrl.imm_type = IMM_R;
                    o_ctrl.rf_write = 1'b1;
                    o_ctrl.muldiv   = 1'b1;
                    o_rs1_used      = 1'b1;
                    o_rs2_used      = 1'b1;
                end
`endif
                else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_MISC_MEM: begin
                if (w_funct3 == F3_FENCE) begin
                    o_ctrl.imm_type = IMM_I;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            OPC_SYSTEM: begin
                if (i_inst == INST_ECALL || i_inst == INST_EBREAK) begin
                    o_ctrl.imm_type = IMM_I;
                end else begin
                    o_ctrl = illegalCtrl();
                end
            end
            default: begin
                o_ctrl = illegalCtrl();
            end
        endcase
    end

endmodule

// File: rtl/decode_ctrl.sv
// Decode stage: decodes instructions as they are accepted from fetch and
// buffers up to DEPTH decoded entries, stalling the head on a load-use hazard
// against the instruction in EX. RV32M_EN enables M-extension decode.
module decode_ctrl
    import decode_ctrl_pkg::*;
#(
    parameter int INST_WIDTH = 32,
    parameter int XLEN       = 32,
    parameter int DEPTH      = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [INST_WIDTH-1:0] in_inst,
    input  logic [XLEN-1:0]       in_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output ctrl_t                 out_ctrl,
    output logic [INST_WIDTH-1:0] out_inst,
    output logic [XLEN-1:0]       out_pc,
    input  logic [4:0]            ex_rd,
    input  logic                  ex_mem_read,
    output logic [31:0]           hazard_cnt
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);

    ctrl_t                 r_ctrlMem [DEPTH];
    logic [INST_WIDTH-1:0] r_instMem [DEPTH];
    logic [XLEN-1:0]       r_pcMem   [DEPTH];
    logic [DEPTH-1:0]      r_rs1Mem;
    logic [DEPTH-1:0]      r_rs2Mem;

    logic [PTR_W-1:0] r_wrPtr;
    logic [PTR_W-1:0] r_rdPtr;
    logic [CNT_W-1:0] r_count;
    logic [31:0]      r_hazardCnt;

    ctrl_t                 w_decCtrl;
    logic                  w_decRs1;
    logic                  w_decRs2;
    logic                  w_push;
    logic                  w_pop;
    logic                  w_notEmpty;
    logic                  w_hazard;
    logic [INST_WIDTH-1:0] w_headInst;

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(DEPTH - 1)) begin
            return '0;
        end
        return p + 1'b1;
    endfunction

    rv32_decoder u_decoder (
        .i_inst     (in_inst[31:0]),
        .o_ctrl     (w_decCtrl),
        .o_rs1_used (w_decRs1),
        .o_rs2_used (w_decRs2)
    );

    assign w_notEmpty = (r_count != '0);
    assign w_headInst = r_instMem[r_rdPtr];
    assign w_hazard   = w_notEmpty && ex_mem_read && (ex_rd != 5'd0) &&
                        ((r_rs1Mem[r_rdPtr] && (w_headInst[19:15] == ex_rd)) ||
                         (r_rs2Mem[r_rdPtr] && (w_headInst[24:20] == ex_rd)));

    assign in_ready   = rst_n && (r_count < CNT_W'(DEPTH));
    assign out_valid  = w_notEmpty && !w_hazard;
    assign w_push     = in_valid && in_ready && !flush;
    assign w_pop      = out_valid && out_ready;

    assign out_ctrl   = r_ctrlMem[r_rdPtr];
    assign out_inst   = w_headInst;
    assign out_pc     = r_pcMem[r_rdPtr];
    assign hazard_cnt = r_hazardCnt;

    // Capture the decoded entry into the tail slot on every accepted push
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_ctrlMem[r_wrPtr] <= w_decCtrl;
            r_instMem[r_wrPtr] <= in_inst;
            r_pcMem[r_wrPtr]   <= in_pc;
            r_rs1Mem[r_wrPtr]  <= w_decRs1;
            r_rs2Mem[r_wrPtr]  <= w_decRs2;
        end
    end

    // Track pointers and occupancy; reset and flush both empty the buffer
    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= nextPtr(r_wrPtr);
            end
            if (w_pop) begin
                r_rdPtr <= nextPtr(r_rdPtr);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + CNT_W'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - CNT_W'(1);
            end
        end
    end

    // Count load-use stall cycles, saturating; flush deliberately leaves it alone
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_hazardCnt <= '0;
        end else if (w_hazard && (r_hazardCnt != 32'hFFFF_FFFF)) begin
            r_hazardCnt <= r_hazardCnt + 32'd1;
        end
    end

endmodule

// File: tb/tb_decode_ctrl.sv
// Self-checking bench for decode_ctrl: directed scenarios plus a randomized
// run against a queue-based reference model. Honours RV32M_EN like the RTL.
module tb_decode_ctrl;
    import decode_ctrl_pkg::*;

    localparam int DEPTH = 2;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_inst;
    logic [31:0] in_pc;
    logic        out_valid;
    logic        out_ready;
    ctrl_t       out_ctrl;
    logic [31:0] out_inst;
    logic [31:0] out_pc;
    logic [4:0]  ex_rd;
    logic        ex_mem_read;
    logic [31:0] hazard_cnt;

    int checks   = 0;
    int failures = 0;

    typedef enum int {K_LUI, K_AUIPC, K_JAL, K_JALR, K_BR, K_LD, K_ST, K_OPI,
                      K_OP, K_MD, K_FENCE, K_SYS, K_ILL} kind_e;

    typedef struct {
        logic [31:0] inst;
        logic [31:0] pc;
    } entry_t;

    decode_ctrl #(.INST_WIDTH(32), .XLEN(32), .DEPTH(DEPTH)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_inst     (in_inst),
        .in_pc       (in_pc),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_ctrl    (out_ctrl),
        .out_inst    (out_inst),
        .out_pc      (out_pc),
        .ex_rd       (ex_rd),
        .ex_mem_read (ex_mem_read),
        .hazard_cnt  (hazard_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("[TB] FAIL watchdog got=timeout want=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Name the instruction class straight from the ISA encoding tables
    function automatic kind_e classify(input logic [31:0] w);
        logic [6:0] op;
        logic [2:0] f3;
        logic [6:0] f7;
        op = w[6:0];
        f3 = w[14:12];
        f7 = w[31:25];
        if (op == 7'h37) return K_LUI;
        if (op == 7'h17) return K_AUIPC;
        if (op == 7'h6F) return K_JAL;
        if (op == 7'h67) return (f3 == 3'd0) ? K_JALR : K_ILL;
        if (op == 7'h63) return (f3 == 3'd2 || f3 == 3'd3) ? K_ILL : K_BR;
        if (op == 7'h03) return (f3 == 3'd3 || f3 >= 3'd6) ? K_ILL : K_LD;
        if (op == 7'h23) return (f3 <= 3'd2) ? K_ST : K_ILL;
        if (op == 7'h13) begin
            if (f3 == 3'd1) return (f7 == 7'h00) ? K_OPI : K_ILL;
            if (f3 == 3'd5) return (f7 == 7'h00 || f7 == 7'h20) ? K_OPI : K_ILL;
            return K_OPI;
        end
        if (op == 7'h33) begin
            if (f7 == 7'h00) return K_OP;
            if (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5)) return K_OP;
            if (f7 == 7'h01) return K_MD;
            return K_ILL;
        end
        if (op == 7'h0F) return (f3 == 3'd0) ? K_FENCE : K_ILL;
        if (w == 32'h0000_0073 || w == 32'h0010_0073) return K_SYS;
        return K_ILL;
    endfunction

    function automatic mem_mode_e modeOf(input logic [2:0] f3);
        case (f3)
            3'd0:    return MEM_BYTE;
            3'd1:    return MEM_HALF;
            3'd2:    return MEM_WORD;
            3'd4:    return MEM_BYTEU;
            default: return MEM_HALFU;
        endcase
    endfunction

    // Expected control bundle and operand usage for one instruction word
    task automatic expDecode(input logic [31:0] w, output ctrl_t c, output bit r1, output bit r2);
        kind_e k;
        k  = classify(w);
        c  = '0;
        r1 = 1'b0;
        r2 = 1'b0;
`ifndef RV32M_EN
        if (k == K_MD) k = K_ILL;
`endif
        case (k)
            K_LUI, K_AUIPC: begin c.imm_type = IMM_U; c.rf_write = 1'b1; end
            K_JAL:   begin c.imm_type = IMM_J; c.rf_write = 1'b1; c.jump = 1'b1; end
            K_JALR:  begin c.imm_type = IMM_I; c.rf_write = 1'b1; c.jalr = 1'b1; r1 = 1'b1; end
            K_BR:    begin c.imm_type = IMM_B; c.branch = 1'b1; r1 = 1'b1; r2 = 1'b1; end
            K_LD:    begin
                c.imm_type = IMM_I; c.dmem_read = 1'b1; c.wb_sel_mem = 1'b1;
                c.rf_write = 1'b1; c.dmem_mode = modeOf(w[14:12]); r1 = 1'b1;
            end
            K_ST:    begin
                c.imm_type = IMM_S; c.dmem_write = 1'b1;
                c.dmem_mode = modeOf(w[14:12]); r1 = 1'b1; r2 = 1'b1;
            end
            K_OPI:   begin c.imm_type = IMM_I; c.alu_src_imm = 1'b1; c.rf_write = 1'b1; r1 = 1'b1; end
            K_OP:    begin c.imm_type = IMM_R; c.rf_write = 1'b1; r1 = 1'b1; r2 = 1'b1; end
            K_MD:    begin c.imm_type = IMM_R; c.rf_write = 1'b1; c.muldiv = 1'b1; r1 = 1'b1; r2 = 1'b1; end
            K_FENCE, K_SYS: c.imm_type = IMM_I;
            default: begin c.imm_type = IMM_NOP; c.illegal = 1'b1; end
        endcase
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; in_inst = '0; in_pc = '0;
        tick();
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        ex_mem_read = 1'b0; ex_rd = 5'd0; in_inst = '0; in_pc = '0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready_async got=%b want=0", in_ready); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_out_valid got=%b want=0", out_valid); end
        checks++;
        if (hazard_cnt !== 32'd0) begin failures++; $display("[TB] FAIL reset_hazard_cnt got=%0d want=0", hazard_cnt); end
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_in_ready_held got=%b want=0", in_ready); end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("[TB] FAIL reset_release_in_ready got=%b want=1", in_ready); end
    endtask

    task automatic test_addi();
        doReset();
        in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h0000_0100; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL addi_latency got=%b want=0", out_valid); end
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1) begin failures++; $display("[TB] FAIL addi_valid got=%b want=1", out_valid); end
        checks++;
        if (out_ctrl.imm_type !== IMM_I || out_ctrl.alu_src_imm !== 1'b1 ||
            out_ctrl.rf_write !== 1'b1 || out_ctrl.illegal !== 1'b0) begin
            failures++; $display("[TB] FAIL addi_ctrl got=%h want imm=I alu_imm=1 rf=1 ill=0", out_ctrl);
        end
        checks++;
        if (out_pc !== 32'h0000_0100) begin failures++; $display("[TB] FAIL addi_pc got=%h want=00000100", out_pc); end
        tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL addi_drained got=%b want=0", out_valid); end
    endtask

    task automatic test_illegal_and_mul();
        ctrl_t want;
        bit    r1;
        bit    r2;
        doReset();
        in_valid = 1'b1; in_inst = 32'h0000_0000; in_pc = 32'h40; out_ready = 1'b0;
        tick();
        in_inst = 32'h0220_81B3; in_pc = 32'h44;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_ctrl !== 20'h00001 || out_inst !== 32'h0) begin
            failures++; $display("[TB] FAIL illegal_zero got=%h want=00001", out_ctrl);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        #1;
        checks++;
`ifdef RV32M_EN
        if (out_ctrl.muldiv !== 1'b1 || out_ctrl.rf_write !== 1'b1 || out_ctrl.illegal !== 1'b0) begin
            failures++; $display("[TB] FAIL mul_enabled got=%h want muldiv=1 rf=1 ill=0", out_ctrl);
        end
`else
        if (out_ctrl.illegal !== 1'b1 || out_ctrl.muldiv !== 1'b0 || out_ctrl.rf_write !== 1'b0) begin
            failures++; $display("[TB] FAIL mul_disabled got=%h want ill=1 muldiv=0 rf=0", out_ctrl);
        end
`endif
        expDecode(32'h0220_81B3, want, r1, r2);
        checks++;
        if (out_ctrl !== want) begin failures++; $display("[TB] FAIL mul_full got=%h want=%h", out_ctrl, want); end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_load_use();
        doReset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0000_A103; in_pc = 32'h200;
        tick();
        in_inst = 32'h0011_01B3; in_pc = 32'h204;
        tick();
        in_valid = 1'b0; out_ready = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0000_A103) begin
            failures++; $display("[TB] FAIL lu_load_head got=%b/%h want=1/0000a103", out_valid, out_inst);
        end
        tick();
        ex_rd = 5'd2; ex_mem_read = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL lu_stall got=%b want=0", out_valid); end
        for (int i = 1; i <= 3; i++) begin
            tick();
            checks++;
            if (out_valid !== 1'b0 || hazard_cnt !== 32'(i)) begin
                failures++; $display("[TB] FAIL lu_stall_count got=%b/%0d want=0/%0d", out_valid, hazard_cnt, i);
            end
        end
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_inst !== 32'h0011_01B3 || out_pc !== 32'h204) begin
            failures++; $display("[TB] FAIL lu_release got=%b/%h/%h want=1/001101b3/204", out_valid, out_inst, out_pc);
        end
        tick();
        checks++;
        if (out_valid !== 1'b0 || hazard_cnt !== 32'd3) begin
            failures++; $display("[TB] FAIL lu_after got=%b/%0d want=0/3", out_valid, hazard_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_fill();
        doReset();
        out_ready = 1'b0;
        for (int i = 0; i <= DEPTH; i++) begin
            in_valid = 1'b1;
            in_inst  = 32'h0000_0013 | (32'(i) << 20);
            in_pc    = 32'h1000 + 32'(4 * i);
            #1;
            checks++;
            if (in_ready !== (i < DEPTH)) begin
                failures++; $display("[TB] FAIL fill_ready[%0d] got=%b want=%b", i, in_ready, (i < DEPTH));
            end
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            #1;
            checks++;
            if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4 * i) ||
                out_inst !== (32'h0000_0013 | (32'(i) << 20))) begin
                failures++; $display("[TB] FAIL fill_order[%0d] got=%b/%h want=1/%h", i, out_valid, out_pc, 32'h1000 + 32'(4 * i));
            end
            tick();
        end
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("[TB] FAIL fill_empty got=%b want=0", out_valid); end
        out_ready = 1'b0;
    endtask

    task automatic test_flush();
        doReset();
        out_ready = 1'b0;
        in_valid = 1'b1; in_inst = 32'h0011_01B3;
        for (int i = 0; i < DEPTH; i++) begin
            in_pc = 32'h300 + 32'(4 * i);
            tick();
        end
        in_valid = 1'b0; ex_rd = 5'd2; ex_mem_read = 1'b1;
        tick();
        tick();
        ex_mem_read = 1'b0; flush = 1'b1; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h3FC;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL flush_full got=%b want=0", in_ready); end
        tick();
        flush = 1'b0; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || hazard_cnt !== 32'd2) begin
            failures++; $display("[TB] FAIL flush_clear got=%b/%b/%0d want=0/1/2", out_valid, in_ready, hazard_cnt);
        end
        in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h400;
        tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h400) begin
            failures++; $display("[TB] FAIL flush_refill got=%b/%h want=1/400", out_valid, out_pc);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        doReset();
        out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0050_0093; in_pc = 32'h500;
        tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin failures++; $display("[TB] FAIL midreset_ready got=%b want=0", in_ready); end
        tick();
        rst_n = 1'b1; in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || hazard_cnt !== 32'd0) begin
            failures++; $display("[TB] FAIL midreset_clear got=%b/%b/%0d want=0/1/0", out_valid, in_ready, hazard_cnt);
        end
    endtask

    task automatic test_random();
        entry_t      q[$];
        entry_t      e;
        logic [31:0] w;
        logic [6:0]  ops[11];
        ctrl_t       hc;
        bit          hr1;
        bit          hr2;
        bit          expHaz;
        bit          expValid;
        bit          expReady;
        int          hazCnt;
        ops = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h0F, 7'h73};
        doReset();
        hazCnt = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            w = $urandom;
            if ($urandom_range(0, 7) != 0) begin
                w[6:0] = ops[$urandom_range(0, 10)];
                w[19:15] = 5'($urandom_range(0, 3));
                w[24:20] = 5'($urandom_range(0, 3));
                case ($urandom_range(0, 3))
                    0: w[31:25] = 7'h00;
                    1: w[31:25] = 7'h20;
                    2: w[31:25] = 7'h01;
                    default: ;
                endcase
            end
            in_inst     = w;
            in_pc       = $urandom;
            in_valid    = 1'($urandom_range(0, 1));
            out_ready   = ($urandom_range(0, 3) != 0);
            ex_mem_read = ($urandom_range(0, 2) == 0);
            ex_rd       = 5'($urandom_range(0, 3));
            flush       = ($urandom_range(0, 24) == 0);
            #2;
            expReady = (q.size() < DEPTH);
            expHaz   = 1'b0;
            if (q.size() > 0) begin
                expDecode(q[0].inst, hc, hr1, hr2);
                expHaz = ex_mem_read && (ex_rd != 0) &&
                         ((hr1 && q[0].inst[19:15] == ex_rd) || (hr2 && q[0].inst[24:20] == ex_rd));
            end
            expValid = (q.size() > 0) && !expHaz;
            checks++;
            if (in_ready !== expReady) begin failures++; $display("[TB] FAIL rnd_in_ready c%0d got=%b want=%b", cyc, in_ready, expReady); end
            checks++;
            if (out_valid !== expValid) begin failures++; $display("[TB] FAIL rnd_out_valid c%0d got=%b want=%b", cyc, out_valid, expValid); end
            checks++;
            if (hazard_cnt !== 32'(hazCnt)) begin failures++; $display("[TB] FAIL rnd_hazard_cnt c%0d got=%0d want=%0d", cyc, hazard_cnt, hazCnt); end
            if (q.size() > 0) begin
                checks++;
                if (out_inst !== q[0].inst || out_pc !== q[0].pc || out_ctrl !== hc) begin
                    failures++;
                    $display("[TB] FAIL rnd_head c%0d got=%h/%h/%h want=%h/%h/%h", cyc, out_inst, out_pc, out_ctrl, q[0].inst, q[0].pc, hc);
                end
            end
            if (expHaz) hazCnt++;
            if (flush) begin
                q.delete();
            end else begin
                if (expValid && out_ready) void'(q.pop_front());
                if (in_valid && expReady) begin
                    e.inst = in_inst;
                    e.pc   = in_pc;
                    q.push_back(e);
                end
            end
            tick();
        end
        flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0; ex_mem_read = 1'b0;
    endtask

    initial begin
        test_reset();
        test_addi();
        test_illegal_and_mul();
        test_load_use();
        test_fill();
        test_flush();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
